rega_timer_ctrl: RTL and testbench
==================================

Name: rega_timer_ctrl

Overview:
- Controls the irrigation-duration timer: loads a user MM:SS BCD preset, counts it down once per second, and holds the valve output active while counting.
- Internally sequences a cascade of four BCD down-counting digits (sec units, sec tens, min units, min tens) with borrow chaining, load and terminal-count detection.
- Sits between the user preset/keys logic and the valve driver; consumes an external 1 Hz tick.

Parameters:
- TICK_IGNORE_LOAD, 1, when 1 a tick arriving in the LOAD cycle is discarded; when 0 it is applied in the first RUN cycle.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tick  in  1  one-cycle pulse, 1 Hz, synchronous to clk
- start  in  1  one-cycle pulse, begin watering with current preset
- pause  in  1  one-cycle pulse, toggles RUN/PAUSE
- stop  in  1  one-cycle pulse, abort
- preset_bcd  in  16  {min_t, min_u, sec_t, sec_u}, BCD nibbles
- count_bcd  out  16  current remaining time, same packing
- valve_on  out  1  registered, high only in RUN
- busy  out  1  high in LOAD, RUN, PAUSE
- done  out  1  one-cycle pulse on natural expiry
- preset_err  out  1  one-cycle pulse on rejected start

Behaviour:
- Clock/reset: one clock (clk); reset asynchronous, active-low (rst_n). While rst_n=0: state IDLE, count_bcd=16'h0000, valve_on=busy=done=preset_err=0. Applies immediately, including mid-run.
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- Preset valid iff every nibble <=9, sec_t <=5, and value != 00:00.
- IDLE: start with valid preset -> LOAD. start with invalid preset -> preset_err=1 for one cycle, stay IDLE. pause/stop/tick ignored.
- LOAD (1 cycle): count_bcd <= preset_bcd; -> RUN. preset_bcd sampled in this cycle only.
- Latency: start in cycle n -> LOAD n+1 -> RUN n+2, so valve_on=1 from cycle n+2.
- RUN: tick decrements count by one second.
  - sec_u 0->9 with borrow.
  - sec_t 0->5 with borrow, only if borrowed into.
  - min_u 0->9 with borrow.
  - min_t decremented when borrowed into.
  - Result registered next cycle.
  - Tick when count = 00:01 -> count 00:00, state DONE.
- DONE (1 cycle): done=1, valve_on=0, busy=0; count_bcd holds 0000; -> IDLE.
- PAUSE: valve_on=0, busy=1, count holds, ticks ignored. pause -> RUN.
- Priority within a cycle: stop > pause > tick.
  - stop in LOAD/RUN/PAUSE -> IDLE, count_bcd=0000, no done pulse.
  - pause and tick together in RUN -> PAUSE, no decrement.
- start outside IDLE is ignored. start and stop together in IDLE: start is honoured.
- Max duration 99:59. Count never wraps below 00:00; the DONE transition guarantees this.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package rega_pkg holds:
  - state enum (IDLE, LOAD, RUN, PAUSE, DONE)
  - BCD_MAX_UNITS=9, BCD_MAX_SEC_TENS=5
  - the nibble-field index constants for preset_bcd/count_bcd packing
- One sub-module, bcd_digit_down, instantiated four times.
  - Parameter MAX.
  - Inputs: clk, rst_n, load, load_val[3:0], dec, clr.
  - Outputs: q[3:0], borrow_out (= dec & q==0; on that cycle q reloads MAX).
  - The controller chains each digit's borrow_out into the next digit's dec and computes the 00:01 terminal detect.

Test Plan:
- Preset 00:03, start pulse, three ticks spaced 10 cycles -> valve_on high 2 cycles after start; count 0002, 0001, 0000 after each tick; done one cycle after third tick with valve_on=0, busy=0; state IDLE the next cycle.
- Preset 10:00, one tick -> 09:59. Then preset 01:00, one tick -> 00:59. Then preset 99:59, one tick -> 99:58.
- Presets 00:60, 00:00, 0A:00 with start -> one-cycle preset_err each; valve_on, busy stay 0; count_bcd unchanged.
- Preset 00:05 RUN at 0005: pause coincident with tick -> count stays 0005, valve_on=0; three ticks while paused -> still 0005; pause -> RUN; next tick -> 0004.
- Mid-run at 0003: stop -> IDLE, count 0000, no done. Restart, then drive rst_n=0 asynchronously between clock edges -> all outputs 0 immediately; no done after release.
- Start pulses repeated during RUN at 0002 -> ignored, count continues 0001, 0000, done once.

Source files
------------

// File: rtl/rega_pkg.sv
// Shared types and constants for the irrigation timer controller.
package rega_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_PAUSE,
      ST_DONE
   } state_t;

   localparam logic [3:0] BCD_MAX_UNITS    = 4'd9;
   localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

   localparam int DIGIT_W   = 4;
   localparam int SEC_U_LSB = 0;
   localparam int SEC_T_LSB = 4;
   localparam int MIN_U_LSB = 8;
   localparam int MIN_T_LSB = 12;

   // A preset is usable only if it is proper MM:SS BCD and not zero length.
   function automatic logic preset_valid(input logic [15:0] p);
      logic ok;
      ok = (p[SEC_U_LSB +: DIGIT_W] <= BCD_MAX_UNITS)
         & (p[SEC_T_LSB +: DIGIT_W] <= BCD_MAX_SEC_TENS)
         & (p[MIN_U_LSB +: DIGIT_W] <= BCD_MAX_UNITS)
         & (p[MIN_T_LSB +: DIGIT_W] <= BCD_MAX_UNITS)
         & (p != 16'h0000);
      return ok;
   endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit; borrows and reloads MAX when decremented at zero.
module bcd_digit_down
   import rega_pkg::*;
#(
   parameter logic [3:0] MAX = BCD_MAX_UNITS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   input  logic       clr,
   output logic [3:0] q,
   output logic       borrow_out
);

   assign borrow_out = dec & (q == 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 4'd0;
      end else if (clr) begin
         q <= 4'd0;
      end else if (load) begin
         q <= load_val;
      end else if (dec) begin
         q <= (q == 4'd0) ? MAX : (q - 4'd1);
      end
   end

endmodule

// File: rtl/rega_timer_ctrl.sv
// Irrigation duration timer: loads an MM:SS preset, counts down on 1 Hz ticks, drives the valve.
module rega_timer_ctrl
   import rega_pkg::*;
#(
   parameter bit TICK_IGNORE_LOAD = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick,
   input  logic        start,
   input  logic        pause,
   input  logic        stop,
   input  logic [15:0] preset_bcd,
   output logic [15:0] count_bcd,
   output logic        valve_on,
   output logic        busy,
   output logic        done,
   output logic        preset_err
);

   state_t     state;
   logic       tick_pend;
   logic       run_tick;
   logic       digit_clr;
   logic       digit_load;
   logic       count_ends;
   logic [3:0] borrow;

   assign run_tick   = (state == ST_RUN) & (tick | tick_pend) & ~stop & ~pause;
   assign digit_clr  = stop & ((state == ST_LOAD) | (state == ST_RUN) | (state == ST_PAUSE));
   assign digit_load = (state == ST_LOAD);
   // A borrow out of the minute tens could only come from decrementing 00:00; treat it as expiry too.
   assign count_ends = (count_bcd == 16'h0001) | borrow[3];

   bcd_digit_down #(.MAX(BCD_MAX_UNITS)) u_sec_u (
      .clk(clk), .rst_n(rst_n), .load(digit_load),
      .load_val(preset_bcd[SEC_U_LSB +: DIGIT_W]), .dec(run_tick), .clr(digit_clr),
      .q(count_bcd[SEC_U_LSB +: DIGIT_W]), .borrow_out(borrow[0])
   );

   bcd_digit_down #(.MAX(BCD_MAX_SEC_TENS)) u_sec_t (
      .clk(clk), .rst_n(rst_n), .load(digit_load),
      .load_val(preset_bcd[SEC_T_LSB +: DIGIT_W]), .dec(borrow[0]), .clr(digit_clr),
      .q(count_bcd[SEC_T_LSB +: DIGIT_W]), .borrow_out(borrow[1])
   );

   bcd_digit_down #(.MAX(BCD_MAX_UNITS)) u_min_u (
      .clk(clk), .rst_n(rst_n), .load(digit_load),
      .load_val(preset_bcd[MIN_U_LSB +: DIGIT_W]), .dec(borrow[1]), .clr(digit_clr),
      .q(count_bcd[MIN_U_LSB +: DIGIT_W]), .borrow_out(borrow[2])
   );

   bcd_digit_down #(.MAX(BCD_MAX_UNITS)) u_min_t (
      .clk(clk), .rst_n(rst_n), .load(digit_load),
      .load_val(preset_bcd[MIN_T_LSB +: DIGIT_W]), .dec(borrow[2]), .clr(digit_clr),
      .q(count_bcd[MIN_T_LSB +: DIGIT_W]), .borrow_out(borrow[3])
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         valve_on   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         preset_err <= 1'b0;
         tick_pend  <= 1'b0;
      end else begin
         done       <= 1'b0;
         preset_err <= 1'b0;
         tick_pend  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (preset_valid(preset_bcd)) begin
                     state <= ST_LOAD;
                     busy  <= 1'b1;
                  end else begin
                     preset_err <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (stop) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state     <= ST_RUN;
                  valve_on  <= 1'b1;
                  // A tick landing in LOAD is either dropped or carried into the first RUN cycle.
                  tick_pend <= tick & ~TICK_IGNORE_LOAD;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state    <= ST_IDLE;
                  valve_on <= 1'b0;
                  busy     <= 1'b0;
               end else if (pause) begin
                  state    <= ST_PAUSE;
                  valve_on <= 1'b0;
               end else if (run_tick && count_ends) begin
                  state    <= ST_DONE;
                  valve_on <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end
            end
            ST_PAUSE: begin
               if (stop) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (pause) begin
                  state    <= ST_RUN;
                  valve_on <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state    <= ST_IDLE;
               valve_on <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rega_timer_ctrl.sv
// Self-checking bench for rega_timer_ctrl: directed scenarios plus randomized traffic against a seconds-based model.
module tb_rega_timer_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick = 1'b0;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] preset_bcd = 16'h0000;
   logic [15:0] count_bcd;
   logic        valve_on;
   logic        busy;
   logic        done;
   logic        preset_err;

   int n_checks = 0;
   int n_errors = 0;

   rega_timer_ctrl #(.TICK_IGNORE_LOAD(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .pause(pause), .stop(stop),
      .preset_bcd(preset_bcd), .count_bcd(count_bcd), .valve_on(valve_on), .busy(busy),
      .done(done), .preset_err(preset_err)
   );

   always #5 clk = ~clk;

   localparam int M_IDLE  = 0;
   localparam int M_LOAD  = 1;
   localparam int M_RUN   = 2;
   localparam int M_PAUSE = 3;
   localparam int M_DONE  = 4;

   int m_mode = M_IDLE;
   int m_secs = 0;
   bit m_done = 1'b0;
   bit m_err  = 1'b0;

   function automatic bit preset_ok(input logic [15:0] p);
      int mt, mu, st, su;
      mt = int'(p[15:12]);
      mu = int'(p[11:8]);
      st = int'(p[7:4]);
      su = int'(p[3:0]);
      return (mt <= 9) && (mu <= 9) && (st <= 5) && (su <= 9) && (p != 16'h0000);
   endfunction

   function automatic int secs_of(input logic [15:0] p);
      return (int'(p[15:12]) * 10 + int'(p[11:8])) * 60 + int'(p[7:4]) * 10 + int'(p[3:0]);
   endfunction

   function automatic logic [15:0] to_bcd(input int s);
      int mm, ss;
      mm = s / 60;
      ss = s % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   // Behavioural model: remaining time kept as plain seconds.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode <= M_IDLE;
         m_secs <= 0;
         m_done <= 1'b0;
         m_err  <= 1'b0;
      end else begin
         m_done <= 1'b0;
         m_err  <= 1'b0;
         case (m_mode)
            M_IDLE: if (start) begin
               if (preset_ok(preset_bcd)) m_mode <= M_LOAD;
               else m_err <= 1'b1;
            end
            M_LOAD: if (stop) begin
               m_mode <= M_IDLE;
               m_secs <= 0;
            end else begin
               m_mode <= M_RUN;
               m_secs <= secs_of(preset_bcd);
            end
            M_RUN: if (stop) begin
               m_mode <= M_IDLE;
               m_secs <= 0;
            end else if (pause) begin
               m_mode <= M_PAUSE;
            end else if (tick) begin
               m_secs <= m_secs - 1;
               if (m_secs == 1) begin
                  m_mode <= M_DONE;
                  m_done <= 1'b1;
               end
            end
            M_PAUSE: if (stop) begin
               m_mode <= M_IDLE;
               m_secs <= 0;
            end else if (pause) begin
               m_mode <= M_RUN;
            end
            default: m_mode <= M_IDLE;
         endcase
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, want);
      end
   endtask

   always @(negedge clk) begin
      check("model_count", count_bcd, to_bcd(m_secs));
      check("model_valve", {15'd0, valve_on}, {15'd0, m_mode == M_RUN});
      check("model_busy", {15'd0, busy},
            {15'd0, (m_mode == M_LOAD) || (m_mode == M_RUN) || (m_mode == M_PAUSE)});
      check("model_done", {15'd0, done}, {15'd0, m_done});
      check("model_err", {15'd0, preset_err}, {15'd0, m_err});
   end

   // Called at a falling edge: drive for one cycle, return at the next falling edge.
   task automatic drive(input bit s, input bit p, input bit t, input bit sp);
      start = s; pause = p; tick = t; stop = sp;
      @(negedge clk);
      start = 1'b0; pause = 1'b0; tick = 1'b0; stop = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic run_preset(input logic [15:0] p);
      preset_bcd = p;
      drive(1, 0, 0, 0);
      idle(1);
   endtask

   function automatic logic [15:0] rand_preset();
      case ($urandom_range(3))
         0: return to_bcd(int'($urandom_range(20, 1)));
         1: return to_bcd(int'($urandom_range(180, 1)));
         2: return 16'($urandom);
         default: return to_bcd(int'($urandom_range(9)));
      endcase
   endfunction

   initial begin
      idle(2);
      rst_n = 1'b1;
      check("reset_count", count_bcd, 16'h0000);
      check("reset_flags", {12'd0, valve_on, busy, done, preset_err}, 16'h0000);

      // 00:03 full countdown
      run_preset(16'h0003);
      check("t1_valve", {15'd0, valve_on}, 16'h0001);
      check("t1_count", count_bcd, 16'h0003);
      idle(9); drive(0, 0, 1, 0);
      check("t1_tick1", count_bcd, 16'h0002);
      idle(9); drive(0, 0, 1, 0);
      check("t1_tick2", count_bcd, 16'h0001);
      idle(9); drive(0, 0, 1, 0);
      check("t1_tick3", count_bcd, 16'h0000);
      check("t1_done", {13'd0, done, valve_on, busy}, 16'h0004);
      idle(1);
      check("t1_after", {13'd0, done, valve_on, busy}, 16'h0000);

      // Borrow chains
      run_preset(16'h1000); drive(0, 0, 1, 0);
      check("t2_1000", count_bcd, 16'h0959);
      drive(0, 0, 0, 1);
      run_preset(16'h0100); drive(0, 0, 1, 0);
      check("t2_0100", count_bcd, 16'h0059);
      drive(0, 0, 0, 1);
      run_preset(16'h9959); drive(0, 0, 1, 0);
      check("t2_9959", count_bcd, 16'h9958);
      drive(0, 0, 0, 1);
      check("t2_stop", count_bcd, 16'h0000);

      // Rejected presets
      preset_bcd = 16'h0060; drive(1, 0, 0, 0);
      check("t3_err60", {13'd0, preset_err, valve_on, busy}, 16'h0004);
      check("t3_cnt60", count_bcd, 16'h0000);
      preset_bcd = 16'h0000; drive(1, 0, 0, 0);
      check("t3_err00", {13'd0, preset_err, valve_on, busy}, 16'h0004);
      preset_bcd = 16'h0A00; drive(1, 0, 0, 0);
      check("t3_err0A", {13'd0, preset_err, valve_on, busy}, 16'h0004);
      idle(1);
      check("t3_clear", {15'd0, preset_err}, 16'h0000);

      // Pause beats a coincident tick; paused ticks ignored
      run_preset(16'h0005);
      drive(0, 1, 1, 0);
      check("t4_pause_cnt", count_bcd, 16'h0005);
      check("t4_pause_flags", {14'd0, valve_on, busy}, 16'h0001);
      for (int i = 0; i < 3; i++) begin
         idle(2); drive(0, 0, 1, 0);
         check("t4_paused_tick", count_bcd, 16'h0005);
      end
      drive(0, 1, 0, 0);
      check("t4_resume", {15'd0, valve_on}, 16'h0001);
      drive(0, 0, 1, 0);
      check("t4_tick", count_bcd, 16'h0004);
      drive(0, 0, 0, 1);

      // Stop mid-run, then asynchronous reset mid-run
      run_preset(16'h0005);
      drive(0, 0, 1, 0); drive(0, 0, 1, 0);
      check("t5_pre", count_bcd, 16'h0003);
      drive(0, 0, 0, 1);
      check("t5_stop", {12'd0, done, valve_on, busy, preset_err}, 16'h0000);
      check("t5_cnt", count_bcd, 16'h0000);
      run_preset(16'h0005);
      drive(0, 0, 1, 0);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_cnt", count_bcd, 16'h0000);
      check("t5_rst_flags", {12'd0, valve_on, busy, done, preset_err}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 1, 0);
         check("t5_no_done", {15'd0, done}, 16'h0000);
      end

      // Starts during RUN are ignored
      run_preset(16'h0003);
      drive(0, 0, 1, 0);
      drive(1, 0, 0, 0);
      check("t6_start_ign", count_bcd, 16'h0002);
      drive(0, 0, 1, 0);
      check("t6_0001", count_bcd, 16'h0001);
      drive(1, 0, 0, 0);
      drive(0, 0, 1, 0);
      check("t6_done", {14'd0, done, count_bcd == 16'h0000}, 16'h0003);
      idle(1);
      check("t6_once", {15'd0, done}, 16'h0000);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if (m_mode != M_LOAD && $urandom_range(7) == 0) preset_bcd = rand_preset();
         start = ($urandom_range(15) == 0);
         pause = ($urandom_range(31) == 0);
         stop  = ($urandom_range(63) == 0);
         tick  = ($urandom_range(5) == 0);
         if (i == 2000) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      start = 1'b0; pause = 1'b0; stop = 1'b0; tick = 1'b0;
      idle(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
